mdu_ctrl: RTL and testbench
===========================

Name: mdu_ctrl

Overview:
- Multi-cycle multiply/divide sequencer in the EX stage; services div, divu, mult and multu.
- Runs a shared 32-iteration shift datapath (shift-add multiply, restoring divide) on operands handed over by EX.
- Holds the pipeline through the stall request path while busy.
- Delivers a 64-bit hi/lo result with a one-cycle write pulse, consumed alongside the existing hi/lo write bus.

Parameters:
- ITER, 32, iterations per operation; equals the operand width; fixed at 32.
- CNT_W, 6, width of the iteration counter.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-low.
- op_div  in  1  start signed divide; one-cycle pulse from EX.
- op_divu  in  1  start unsigned divide.
- op_mult  in  1  start signed multiply.
- op_multu  in  1  start unsigned multiply.
- src_a  in  32  rs value (dividend / multiplicand).
- src_b  in  32  rt value (divisor / multiplier).
- cancel  in  1  flush; abort the current operation.
- stallreq  out  1  stall request to the pipeline controller.
- busy  out  1  FSM not in IDLE.
- hilo_we  out  1  one-cycle result-valid / hi-lo write pulse.
- hi  out  32  remainder (div) or product[63:32] (mult).
- lo  out  32  quotient (div) or product[31:0] (mult).

Behaviour:
- Reset (rst low, asynchronous):
  - FSM goes to IDLE.
  - stallreq=0, busy=0, hilo_we=0, hi=0, lo=0, counter=0.
  - Takes effect mid-operation with no result.
- FSM states: IDLE, PREP, RUN, FIX, DONE.
- IDLE:
  - Any start bit high at cycle T latches the op and operands, and moves to PREP at T+1.
  - If several start bits are high, priority is div > divu > mult > multu.
- PREP:
  - Signed ops take the magnitudes of both operands and record the result signs:
    - quotient/product negative when the operand signs differ;
    - remainder takes the dividend sign.
  - Unsigned ops use the raw operands.
  - Divide with divisor 0 goes to FIX with quotient=32'hFFFF_FFFF, remainder=|dividend|.
  - Multiply with multiplier 0 goes to FIX with product 0.
  - Otherwise go to RUN with counter=0.
- RUN, one iteration per cycle:
  - Multiply: if multiplier bit0, add the 64-bit multiplicand register to the product. Then shift the multiplicand left 1 and the multiplier right 1.
  - Divide: shift {rem,quot} left 1; trial-subtract the divisor from rem[32:0]; if non-negative, keep the difference and set quot bit0.
  - Counter increments each cycle; move to FIX after iteration ITER-1 completes.
- FIX: apply two's-complement negation per the recorded signs; register hi/lo; go to DONE.
- DONE: hilo_we=1 for exactly this cycle; hi/lo valid; return to IDLE next cycle.
- hi/lo hold their value until the next DONE.
- Latency, start at T:
  - normal: DONE (hilo_we) at T+35 — PREP T+1, RUN T+2..T+33, FIX T+34;
  - zero-skip: DONE at T+3.
- stallreq (combinational) = (any start bit & state==IDLE) | state in {PREP, RUN, FIX}.
  - Low in DONE, so the stalled instruction advances in the same cycle hilo_we fires.
- busy = state != IDLE.
- cancel:
  - In any non-IDLE state: next state IDLE; no hilo_we; hi/lo unchanged; stallreq drops combinationally in the same cycle.
  - cancel together with a start in IDLE: the start is ignored.
- Start bits while busy are ignored; the pipeline guarantees none arrive while stallreq is high.
- Overflow case: div 0x8000_0000 / 0xFFFF_FFFF gives lo=0x8000_0000, hi=0. The natural wrap is accepted; no trap.

Optional Feature:
- Macro MDU_EARLY_EXIT_EN.
- Defined: multiply leaves RUN for FIX as soon as the shifted multiplier register becomes zero after an iteration, so latency varies with the multiplier's highest set bit.
- Defined: divide is unaffected.
- Undefined: every non-zero-skip operation runs exactly ITER iterations, giving fixed T+35 latency.

Test Plan:
- multu 0xFFFF_FFFF x 0xFFFF_FFFF at T → hilo_we only at T+35; hi=0xFFFF_FFFE, lo=0x0000_0001; stallreq high T..T+34, low at T+35.
- mult 0xFFFF_FFFD (-3) x 5 → hi=0xFFFF_FFFF, lo=0xFFFF_FFF1.
- div -7/2 → lo=0xFFFF_FFFD, hi=0xFFFF_FFFF; divu 7/0 → hilo_we at T+3, hi=7, lo=0xFFFF_FFFF.
- div 0x8000_0000 / 0xFFFF_FFFF → lo=0x8000_0000, hi=0; divu 100/7 → lo=14, hi=2.
- cancel at T+10 of a div → IDLE at T+11, stallreq low at T+10, no hilo_we, hi/lo unchanged. rst low at T+20 of a second op → all outputs 0 immediately.
- With MDU_EARLY_EXIT_EN: multu 5 x 3 at T → hilo_we at T+5, lo=15, hi=0. Without it → hilo_we at T+35.

Source files
------------

// File: rtl/mdu_ctrl.sv
// Multi-cycle mult/multu/div/divu sequencer: shared 32-step shift-add / restoring-divide datapath; optional MDU_EARLY_EXIT_EN.
// Latency: hilo_we at start+35 (start+3 on zero divisor/multiplier; variable for multiply with MDU_EARLY_EXIT_EN).
// Backpressure: holds the pipeline with stallreq from start through FIX; cancel aborts and drops stallreq at once.
module mdu_ctrl #(
    parameter int ITER  = 32,
    parameter int CNT_W = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        op_div,
    input  logic        op_divu,
    input  logic        op_mult,
    input  logic        op_multu,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        cancel,
    output logic        stallreq,
    output logic        busy,
    output logic        hilo_we,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [2:0] {IDLE, PREP, RUN, FIX, DONE} state_t;

    state_t             state;
    logic               is_div;
    logic               is_sgn;
    logic               neg_q;
    logic               neg_r;
    logic [63:0]        acc;
    logic [63:0]        mc;
    logic [31:0]        b_reg;
    logic [CNT_W-1:0]   cnt;

    logic               start_any;
    logic [31:0]        a_mag;
    logic [31:0]        b_mag;
    logic [64:0]        div_sh;
    logic [32:0]        div_diff;
    logic [63:0]        div_nxt;
    logic [63:0]        mul_nxt;
    logic [63:0]        prod_fix;
    logic               mul_exit;
    logic               run_exit;

    assign start_any = op_div | op_divu | op_mult | op_multu;

    // mc[31:0] and b_reg hold the raw operands until PREP replaces them with magnitudes
    assign a_mag = (is_sgn && mc[31])    ? -mc[31:0] : mc[31:0];
    assign b_mag = (is_sgn && b_reg[31]) ? -b_reg    : b_reg;

    // acc is {rem, quot} while dividing and the running product while multiplying
    assign div_sh   = {acc, 1'b0};
    assign div_diff = div_sh[64:32] - {1'b0, b_reg};
    assign div_nxt  = div_diff[32] ? div_sh[63:0] : {div_diff[31:0], div_sh[31:1], 1'b1};
    assign mul_nxt  = b_reg[0] ? acc + mc : acc;
    assign prod_fix = neg_q ? -acc : acc;

`ifdef MDU_EARLY_EXIT_EN
    assign mul_exit = (b_reg[31:1] == 31'd0);
`else
    assign mul_exit = 1'b0;
`endif
    assign run_exit = (cnt == CNT_W'(ITER - 1)) | (~is_div & mul_exit);

    assign busy     = (state != IDLE);
    assign stallreq = ~cancel & ((start_any & (state == IDLE)) |
                                 (state == PREP) | (state == RUN) | (state == FIX));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            is_div  <= 1'b0;
            is_sgn  <= 1'b0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            acc     <= 64'd0;
            mc      <= 64'd0;
            b_reg   <= 32'd0;
            cnt     <= '0;
            hilo_we <= 1'b0;
            hi      <= 32'd0;
            lo      <= 32'd0;
        end else begin
            hilo_we <= 1'b0;
            if (cancel && state != IDLE) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (start_any && !cancel) begin
                            state  <= PREP;
                            is_div <= op_div | op_divu;
                            is_sgn <= op_div | (~op_divu & op_mult);
                            mc     <= {32'd0, src_a};
                            b_reg  <= src_b;
                        end
                    end
                    PREP: begin
                        cnt   <= '0;
                        neg_q <= is_sgn & (mc[31] ^ b_reg[31]);
                        neg_r <= is_sgn & mc[31];
                        b_reg <= b_mag;
                        if (is_div) begin
                            if (b_mag == 32'd0) begin
                                // divide by zero: deliver all-ones quotient and |dividend| unsigned
                                acc   <= {a_mag, 32'hFFFF_FFFF};
                                neg_q <= 1'b0;
                                neg_r <= 1'b0;
                                state <= FIX;
                            end else begin
                                acc   <= {32'd0, a_mag};
                                state <= RUN;
                            end
                        end else begin
                            mc    <= {32'd0, a_mag};
                            acc   <= 64'd0;
                            state <= (b_mag == 32'd0) ? FIX : RUN;
                        end
                    end
                    RUN: begin
                        cnt <= cnt + CNT_W'(1);
                        if (is_div) begin
                            acc <= div_nxt;
                        end else begin
                            acc   <= mul_nxt;
                            mc    <= mc << 1;
                            b_reg <= b_reg >> 1;
                        end
                        if (run_exit) state <= FIX;
                    end
                    FIX: begin
                        if (is_div) begin
                            hi <= neg_r ? -acc[63:32] : acc[63:32];
                            lo <= neg_q ? -acc[31:0]  : acc[31:0];
                        end else begin
                            hi <= prod_fix[63:32];
                            lo <= prod_fix[31:0];
                        end
                        hilo_we <= 1'b1;
                        state   <= DONE;
                    end
                    DONE: state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed bench for mdu_ctrl: results, latency, stall window, priority, cancel and reset.
module tb_mdu_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        op_div = 1'b0, op_divu = 1'b0, op_mult = 1'b0, op_multu = 1'b0;
    logic [31:0] src_a = 32'd0, src_b = 32'd0;
    logic        cancel = 1'b0;
    logic        stallreq, busy, hilo_we;
    logic [31:0] hi, lo;

    int errors = 0;
    int checks = 0;

    localparam logic [3:0] OP_DIV = 4'b1000, OP_DIVU = 4'b0100, OP_MULT = 4'b0010, OP_MULTU = 4'b0001;

`ifdef MDU_EARLY_EXIT_EN
    localparam int EARLY = 1;
`else
    localparam int EARLY = 0;
`endif

    mdu_ctrl dut (
        .clk(clk), .rst(rst),
        .op_div(op_div), .op_divu(op_divu), .op_mult(op_mult), .op_multu(op_multu),
        .src_a(src_a), .src_b(src_b), .cancel(cancel),
        .stallreq(stallreq), .busy(busy), .hilo_we(hilo_we), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    // Start at cycle T; returns first hilo_we cycle offset, pulse count and stall-window violations.
    task automatic run_op(input logic [3:0] ops, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output int pulses, output int stall_bad);
        lat = -1; pulses = 0; stall_bad = 0;
        @(posedge clk); #1;
        {op_div, op_divu, op_mult, op_multu} = ops; src_a = a; src_b = b;
        #4;
        if (!stallreq) stall_bad++;
        for (int k = 1; k <= 45; k++) begin
            @(posedge clk); #1;
            if (k == 1) {op_div, op_divu, op_mult, op_multu} = 4'b0000;
            #4;
            if (hilo_we) begin
                pulses++;
                if (lat < 0) lat = k;
                if (stallreq) stall_bad++;
            end else if (lat < 0 && !stallreq) begin
                stall_bad++;
            end
        end
    endtask

    task automatic test_reset;
        #3;
        checks++; if ({stallreq, busy, hilo_we} !== 3'b000) begin errors++; $display("FAIL reset_ctl got %b want 000", {stallreq, busy, hilo_we}); end
        checks++; if ({hi, lo} !== 64'd0) begin errors++; $display("FAIL reset_hilo got %h want 0", {hi, lo}); end
        @(negedge clk); rst = 1'b1;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy got %b want 0", busy); end
    endtask

    task automatic test_mult;
        int lat, pulses, sb;
        run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, pulses, sb);
        checks++; if (lat !== 35) begin errors++; $display("FAIL multu_lat got %0d want 35", lat); end
        checks++; if (pulses !== 1) begin errors++; $display("FAIL multu_pulses got %0d want 1", pulses); end
        checks++; if (sb !== 0) begin errors++; $display("FAIL multu_stall got %0d bad cycles want 0", sb); end
        checks++; if ({hi, lo} !== 64'hFFFF_FFFE_0000_0001) begin errors++; $display("FAIL multu_res got %h want fffffffe00000001", {hi, lo}); end
        run_op(OP_MULT, 32'hFFFF_FFFD, 32'd5, lat, pulses, sb);
        checks++; if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFF1) begin errors++; $display("FAIL mult_res got %h want fffffffffffffff1", {hi, lo}); end
        checks++; if (lat !== (EARLY ? 6 : 35)) begin errors++; $display("FAIL mult_lat got %0d want %0d", lat, EARLY ? 6 : 35); end
    endtask

    task automatic test_div;
        int lat, pulses, sb;
        run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, lat, pulses, sb);
        checks++; if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFFD) begin errors++; $display("FAIL div_neg got %h want ffffffff_fffffffd", {hi, lo}); end
        checks++; if (lat !== 35) begin errors++; $display("FAIL div_lat got %0d want 35", lat); end
        run_op(OP_DIVU, 32'd7, 32'd0, lat, pulses, sb);
        checks++; if (lat !== 3) begin errors++; $display("FAIL divz_lat got %0d want 3", lat); end
        checks++; if ({hi, lo} !== 64'h0000_0007_FFFF_FFFF) begin errors++; $display("FAIL divz_res got %h want 00000007_ffffffff", {hi, lo}); end
        checks++; if (sb !== 0 || pulses !== 1) begin errors++; $display("FAIL divz_stall got bad=%0d pulses=%0d want 0 1", sb, pulses); end
        run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, lat, pulses, sb);
        checks++; if ({hi, lo} !== 64'h0000_0000_8000_0000) begin errors++; $display("FAIL div_ovf got %h want 00000000_80000000", {hi, lo}); end
        run_op(OP_DIVU, 32'd100, 32'd7, lat, pulses, sb);
        checks++; if ({hi, lo} !== {32'd2, 32'd14}) begin errors++; $display("FAIL divu_res got %h want 00000002_0000000e", {hi, lo}); end
        run_op(OP_MULTU, 32'd1234, 32'd0, lat, pulses, sb);
        checks++; if (lat !== 3 || {hi, lo} !== 64'd0) begin errors++; $display("FAIL mulz got lat=%0d res=%h want 3 0", lat, {hi, lo}); end
    endtask

    task automatic test_priority;
        int lat, pulses, sb;
        run_op(4'b1111, 32'hFFFF_FF9C, 32'd7, lat, pulses, sb);
        checks++; if ({hi, lo} !== 64'hFFFF_FFFE_FFFF_FFF2) begin errors++; $display("FAIL prio_res got %h want fffffffe_fffffff2", {hi, lo}); end
    endtask

    task automatic test_cancel;
        logic [63:0] prev;
        int pulses;
        prev = {hi, lo};
        pulses = 0;
        @(posedge clk); #1;
        op_div = 1'b1; src_a = 32'd1000; src_b = 32'd3;
        for (int k = 1; k <= 45; k++) begin
            @(posedge clk); #1;
            if (k == 1) op_div = 1'b0;
            if (k == 10) cancel = 1'b1;
            if (k == 11) cancel = 1'b0;
            #4;
            if (hilo_we) pulses++;
            if (k == 10) begin
                checks++; if (stallreq !== 1'b0) begin errors++; $display("FAIL cancel_stall got %b want 0", stallreq); end
            end
            if (k == 11) begin
                checks++; if (busy !== 1'b0) begin errors++; $display("FAIL cancel_idle got busy=%b want 0", busy); end
            end
        end
        checks++; if (pulses !== 0) begin errors++; $display("FAIL cancel_we got %0d pulses want 0", pulses); end
        checks++; if ({hi, lo} !== prev) begin errors++; $display("FAIL cancel_hilo got %h want %h", {hi, lo}, prev); end
        // cancel with a start in IDLE: start ignored
        @(posedge clk); #1;
        op_mult = 1'b1; cancel = 1'b1; src_a = 32'd3; src_b = 32'd3;
        #4;
        checks++; if (stallreq !== 1'b0) begin errors++; $display("FAIL cstart_stall got %b want 0", stallreq); end
        @(posedge clk); #1;
        op_mult = 1'b0; cancel = 1'b0;
        #4;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL cstart_busy got %b want 0", busy); end
    endtask

    task automatic test_reset_midop;
        @(posedge clk); #1;
        op_multu = 1'b1; src_a = 32'd9; src_b = 32'd9;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (k == 1) op_multu = 1'b0;
        end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_pre busy got %b want 1", busy); end
        rst = 1'b0;
        #1;
        checks++; if ({stallreq, busy, hilo_we, hi, lo} !== 67'd0) begin errors++; $display("FAIL rst_midop got %b/%b/%b %h want all 0", stallreq, busy, hilo_we, {hi, lo}); end
        #2 rst = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (hilo_we) begin
                checks++; errors++; $display("FAIL rst_we got 1 at cycle %0d want 0", k);
            end
        end
    endtask

    task automatic test_early_exit;
        int lat, pulses, sb;
        run_op(OP_MULTU, 32'd5, 32'd3, lat, pulses, sb);
        checks++; if (lat !== (EARLY ? 5 : 35)) begin errors++; $display("FAIL early_lat got %0d want %0d", lat, EARLY ? 5 : 35); end
        checks++; if ({hi, lo} !== 64'd15) begin errors++; $display("FAIL early_res got %h want f", {hi, lo}); end
    endtask

    initial begin
        test_reset;
        test_mult;
        test_div;
        test_priority;
        test_cancel;
        test_reset_midop;
        test_early_exit;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
